// File: rtl/sb_sim_pkg.sv
// Shared types, constants and helpers for the switchboard queue bridges.
// The shared-memory queue is presented to the bridges as a pop/push port
// so the data path stays synthesizable; the owner of the queue handle
// supplies head-of-queue, availability and the valid/ready mode.
package sb_sim_pkg;

    localparam int SB_MAX_DW = 416;

    localparam logic [31:0] SB_MODE_OFF    = 32'd0;
    localparam logic [31:0] SB_MODE_ALWAYS = 32'd1;
    localparam logic [31:0] SB_MODE_RANDOM = 32'd2;

    // x^16+x^14+x^13+x^11+1 as a right-shifting Fibonacci register
    localparam logic [15:0] SB_LFSR_SEED = 16'hACE1;
    localparam logic [15:0] SB_LFSR_TAPS = 16'h002D;

    typedef struct packed {
        logic [31:0]           destination;
        logic [31:0]           flags;
        logic [SB_MAX_DW-1:0]  data;
    } sb_packet;

    function automatic logic [15:0] sb_lfsr_next(input logic [15:0] s);
        return {^(s & SB_LFSR_TAPS), s[15:1]};
    endfunction

    // Unknown mode values fall back to always-on
    function automatic logic sb_mode_permits(input logic [31:0] mode, input logic rnd);
        if (mode == SB_MODE_OFF) begin
            return 1'b0;
        end else if (mode == SB_MODE_RANDOM) begin
            return rnd;
        end
        return 1'b1;
    endfunction

endpackage

// File: rtl/queue_to_sb_sim_if.sv
// Valid/ready beat stream carrying data, dest and last.
interface queue_to_sb_sim_if #(
    parameter int DW = 416
);
    logic [DW-1:0] data;
    logic [31:0]   dest;
    logic          last;
    logic          valid;
    logic          ready;

    modport master (output data, output dest, output last, output valid, input ready);
    modport slave  (input data, input dest, input last, input valid, output ready);
endinterface

// File: rtl/sb_lfsr16.sv
// Free-running 16-bit LFSR used to randomise valid/ready gating.
module sb_lfsr16
    import sb_sim_pkg::*;
(
    input  logic clk,
    input  logic nreset,
    output logic o_bit
);
    logic [15:0] r_state;

    // Advance every edge; reset returns to the seed
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= SB_LFSR_SEED;
        end else begin
            r_state <= sb_lfsr_next(r_state);
        end
    end

    assign o_bit = r_state[0];
endmodule

// File: rtl/sb_to_queue_sim.sv
// Receive half of the channel pair: accepted beats are pushed into a queue,
// a beat that meets a full queue is held and retried with ready low.
module sb_to_queue_sim
    import sb_sim_pkg::*;
#(
    parameter int DW = SB_MAX_DW
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              i_attached,
    input  logic [31:0]       i_ready_mode,
    input  logic              i_q_full,
    output logic              o_q_push,
    output sb_packet          o_q_pkt,
    queue_to_sb_sim_if.slave  bus
);
    logic     r_ready;
    logic     r_held;
    sb_packet r_pkt;
    sb_packet w_beatPkt;
    logic     w_rnd;
    logic     w_accept;
    logic     w_sendReq;
    logic     w_holdNext;

    sb_lfsr16 u_lfsr (
        .clk    (clk),
        .nreset (nreset),
        .o_bit  (w_rnd)
    );

    // Zero-filled packet built from the incoming beat
    always_comb begin
        w_beatPkt             = '0;
        w_beatPkt.destination = bus.dest;
        w_beatPkt.flags[0]    = bus.last;
        w_beatPkt.data[DW-1:0] = bus.data;
    end

    assign w_accept   = bus.valid && r_ready;
    assign w_sendReq  = r_held || w_accept;
    assign w_holdNext = w_sendReq && i_q_full;
    assign o_q_push   = w_sendReq && !i_q_full;
    assign o_q_pkt    = r_held ? r_pkt : w_beatPkt;
    assign bus.ready  = r_ready;

    // Hold a rejected beat and keep ready low until its send succeeds
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_ready <= 1'b0;
            r_held  <= 1'b0;
            r_pkt   <= '0;
        end else begin
            r_held  <= w_holdNext;
            if (w_accept) begin
                r_pkt <= w_beatPkt;
            end
            r_ready <= i_attached && !w_holdNext && sb_mode_permits(i_ready_mode, w_rnd);
        end
    end
endmodule

// File: rtl/queue_to_sb_sim.sv
// Transmit half of the channel pair: pops packets from a queue and presents
// them as valid/ready beats, one per cycle when the slot is free.
module queue_to_sb_sim
    import sb_sim_pkg::*;
#(
    parameter int DW = SB_MAX_DW
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic               i_attached,
    input  logic [31:0]        i_valid_mode,
    input  logic               i_q_avail,
    input  sb_packet           i_q_pkt,
    output logic               o_q_pop,
    queue_to_sb_sim_if.master  bus
);
    logic          r_valid;
    logic          r_last;
    logic [31:0]   r_dest;
    logic [DW-1:0] r_data;
    logic          w_rnd;
    logic          w_slotFree;
    logic          w_attempt;
    logic          w_unusedBits;

    sb_lfsr16 u_lfsr (
        .clk    (clk),
        .nreset (nreset),
        .o_bit  (w_rnd)
    );

    assign w_slotFree   = !r_valid || bus.ready;
    assign w_attempt    = nreset && i_attached && w_slotFree
                          && sb_mode_permits(i_valid_mode, w_rnd);
    assign o_q_pop      = w_attempt && i_q_avail;
    assign w_unusedBits = ^{i_q_pkt.flags[31:1], i_q_pkt.data};

    assign bus.valid = r_valid;
    assign bus.data  = r_data;
    assign bus.dest  = r_dest;
    assign bus.last  = r_last;

    // Refill the output register whenever the current beat is gone
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_dest  <= '0;
            r_data  <= '0;
        end else if (w_slotFree) begin
            r_valid <= o_q_pop;
            if (o_q_pop) begin
                r_data <= i_q_pkt.data[DW-1:0];
                r_dest <= i_q_pkt.destination;
                r_last <= i_q_pkt.flags[0];
            end
        end
    end
endmodule

// File: tb/tb_queue_to_sb_sim.sv
// Directed bench for queue_to_sb_sim with a behavioural queue model and a
// loopback through sb_to_queue_sim into a bounded destination queue.
module tb_queue_to_sb_sim;
    import sb_sim_pkg::*;

    localparam int TB_DW  = 40;
    localparam int Q3_CAP = 4;

    logic        clk;
    logic        nreset;
    logic        attached;
    logic [31:0] mode1;
    logic [31:0] mode2;
    logic [31:0] modeR;
    logic        avail1;
    logic        avail2;
    logic        full3;
    logic        pop1;
    logic        pop2;
    logic        push3;
    sb_packet    head1;
    sb_packet    head2;
    sb_packet    pkt3;

    sb_packet q1[$];
    sb_packet q2[$];
    sb_packet q3[$];

    int checkCount = 0;
    int failCount  = 0;

    queue_to_sb_sim_if #(.DW(TB_DW)) ifA ();
    queue_to_sb_sim_if #(.DW(TB_DW)) ifB ();

    queue_to_sb_sim #(.DW(TB_DW)) dut (
        .clk          (clk),
        .nreset       (nreset),
        .i_attached   (attached),
        .i_valid_mode (mode1),
        .i_q_avail    (avail1),
        .i_q_pkt      (head1),
        .o_q_pop      (pop1),
        .bus          (ifA)
    );

    queue_to_sb_sim #(.DW(TB_DW)) dutLbSrc (
        .clk          (clk),
        .nreset       (nreset),
        .i_attached   (attached),
        .i_valid_mode (mode2),
        .i_q_avail    (avail2),
        .i_q_pkt      (head2),
        .o_q_pop      (pop2),
        .bus          (ifB)
    );

    sb_to_queue_sim #(.DW(TB_DW)) dutLbSink (
        .clk          (clk),
        .nreset       (nreset),
        .i_attached   (attached),
        .i_ready_mode (modeR),
        .i_q_full     (full3),
        .o_q_push     (push3),
        .o_q_pkt      (pkt3),
        .bus          (ifB)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Queue model: pop/push on the edge, then republish head and status
    always @(posedge clk) begin
        if (pop1 && q1.size() != 0) void'(q1.pop_front());
        if (pop2 && q2.size() != 0) void'(q2.pop_front());
        if (push3) q3.push_back(pkt3);
        avail1 <= (q1.size() != 0);
        avail2 <= (q2.size() != 0);
        if (q1.size() != 0) head1 <= q1[0]; else head1 <= '0;
        if (q2.size() != 0) head2 <= q2[0]; else head2 <= '0;
        full3 <= (q3.size() >= Q3_CAP);
    end

    function automatic sb_packet mkPkt(input logic [39:0] d, input logic [31:0] dst, input logic lst);
        sb_packet p;
        p             = '1;
        p.data[39:0]  = d;
        p.destination = dst;
        p.flags[0]    = lst;
        return p;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rdy, input logic [31:0] mode);
        ifA.ready = rdy;
        mode1     = mode;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int rxIdx;
        int orderErrs;
        int validCycles;
        int cycles;
        int seen;
        logic dutyOk;
        sb_packet rx[$];
        sb_packet expPkt;

        nreset   = 1'b0;
        attached = 1'b1;
        mode2    = SB_MODE_ALWAYS;
        modeR    = SB_MODE_ALWAYS;
        applyStimulus(1'b1, SB_MODE_ALWAYS);
        q1.push_back(mkPkt(40'h11, 32'h5, 1'b0));

        // Reset held with a packet waiting
        for (int i = 0; i < 4; i++) begin
            tick(1);
            checkOutput("rst_valid", ifA.valid, 0);
        end
        checkOutput("rst_data", ifA.data, 0);
        nreset = 1'b1;
        tick(1);
        checkOutput("rel_valid", ifA.valid, 1);
        checkOutput("rel_data", ifA.data, 40'h11);
        checkOutput("rel_dest", ifA.dest, 32'h5);
        tick(1);
        checkOutput("rel_empty", ifA.valid, 0);

        // Three back-to-back beats with last on the third
        for (int i = 1; i <= 3; i++) q1.push_back(mkPkt(40'h11 * i, 32'h5, i == 3));
        tick(1);
        checkOutput("b2b_pre", ifA.valid, 0);
        for (int i = 1; i <= 3; i++) begin
            tick(1);
            checkOutput("b2b_valid", ifA.valid, 1);
            checkOutput("b2b_data", ifA.data, 40'h11 * i);
            checkOutput("b2b_last", ifA.last, (i == 3));
        end
        tick(1);
        checkOutput("b2b_end", ifA.valid, 0);

        // Backpressure freezes the presented beat
        applyStimulus(1'b0, SB_MODE_ALWAYS);
        q1.push_back(mkPkt(40'h11, 32'h7, 1'b0));
        q1.push_back(mkPkt(40'h22, 32'h7, 1'b1));
        tick(2);
        checkOutput("bp_first", ifA.data, 40'h11);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            checkOutput("bp_valid", ifA.valid, 1);
            checkOutput("bp_data", ifA.data, 40'h11);
        end
        checkOutput("bp_dest", ifA.dest, 32'h7);
        checkOutput("bp_last", ifA.last, 0);
        applyStimulus(1'b1, SB_MODE_ALWAYS);
        tick(1);
        checkOutput("bp_next_data", ifA.data, 40'h22);
        checkOutput("bp_next_last", ifA.last, 1);
        tick(1);
        checkOutput("bp_end", ifA.valid, 0);

        // Mode 0 lets the current beat complete, then stops fetching
        applyStimulus(1'b0, SB_MODE_ALWAYS);
        q1.push_back(mkPkt(40'h51, 32'h3, 1'b0));
        q1.push_back(mkPkt(40'h52, 32'h3, 1'b0));
        tick(2);
        checkOutput("m0c_data", ifA.data, 40'h51);
        applyStimulus(1'b0, SB_MODE_OFF);
        tick(1);
        checkOutput("m0c_hold", ifA.valid, 1);
        applyStimulus(1'b1, SB_MODE_OFF);
        tick(1);
        checkOutput("m0c_drop", ifA.valid, 0);
        applyStimulus(1'b1, SB_MODE_ALWAYS);
        tick(1);
        checkOutput("m0c_resume", ifA.data, 40'h52);
        tick(1);

        // Mode 0 with packets queued, then switch to mode 1
        applyStimulus(1'b1, SB_MODE_OFF);
        for (int i = 0; i < 4; i++) q1.push_back(mkPkt(40'h41 + 40'(i), 32'h9, 1'b0));
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (ifA.valid) seen++;
        end
        checkOutput("m0_quiet", seen, 0);
        applyStimulus(1'b1, SB_MODE_ALWAYS);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            checkOutput("m0_on_data", {ifA.valid, ifA.data}, {1'b1, 40'h41 + 40'(i)});
        end
        tick(1);
        checkOutput("m0_on_end", ifA.valid, 0);

        // Mode 2: random gating, strict order, no loss
        applyStimulus(1'b1, SB_MODE_RANDOM);
        for (int i = 0; i < 1000; i++) q1.push_back(mkPkt(40'hA0_0000_0000 | 40'(i), 32'(i), 1'b0));
        rxIdx = 0; orderErrs = 0; validCycles = 0; cycles = 0;
        for (int c = 0; c < 5000 && rxIdx < 1000; c++) begin
            tick(1);
            cycles++;
            if (ifA.valid) begin
                if (ifA.data !== (40'hA0_0000_0000 | 40'(rxIdx)) || ifA.dest !== 32'(rxIdx)) orderErrs++;
                rxIdx++;
                validCycles++;
            end
        end
        checkOutput("m2_count", rxIdx, 1000);
        checkOutput("m2_order_errs", orderErrs, 0);
        dutyOk = (validCycles * 100 >= cycles * 30) && (validCycles * 100 <= cycles * 70);
        checkOutput("m2_duty_ok", dutyOk, 1);
        applyStimulus(1'b1, SB_MODE_ALWAYS);
        tick(2);

        // Loopback into a full destination queue, then drain
        for (int i = 0; i < 4; i++) q3.push_back(mkPkt(40'hD0 + 40'(i), 32'hDD, 1'b0));
        for (int i = 0; i < 8; i++) q2.push_back(mkPkt(40'h60 + 40'(i), 32'h100 + 32'(i), i == 7));
        tick(6);
        checkOutput("lb_ready_low", ifB.ready, 0);
        checkOutput("lb_q3_size", q3.size(), Q3_CAP);
        for (int c = 0; c < 300 && rx.size() < 12; c++) begin
            tick(1);
            if (q3.size() != 0) rx.push_back(q3.pop_front());
        end
        checkOutput("lb_rx_count", rx.size(), 12);
        orderErrs = 0;
        for (int i = 0; i < rx.size(); i++) begin
            if (i < 4) begin
                if (rx[i].data[39:0] !== 40'hD0 + 40'(i)) orderErrs++;
            end else begin
                expPkt             = '0;
                expPkt.data[39:0]  = 40'h60 + 40'(i - 4);
                expPkt.destination = 32'h100 + 32'(i - 4);
                expPkt.flags[0]    = (i == 11);
                if (rx[i] !== expPkt) orderErrs++;
            end
        end
        checkOutput("lb_order_errs", orderErrs, 0);
        checkOutput("lb_ready_back", ifB.ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end
endmodule
